// File: rtl/seq_mult.sv
// seq_mult: iterative shift-and-add multiplier, one multiplier bit per clock, valid/ready on both sides.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port for two's-complement operands.
module seq_mult #(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    input  logic               out_ready
`ifdef SEQ_MULT_SIGNED_EN
    ,
    input  logic               signed_mode
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d, mcand_q, mcand_d, out_q, out_d, sum;
    logic [WIDTH-1:0] mplier_q, mplier_d, mag1, mag2;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d, sgn, neg1, neg2;

`ifdef SEQ_MULT_SIGNED_EN
    assign sgn = signed_mode;
`else
    assign sgn = 1'b0;
`endif

    // Signed operands are reduced to magnitudes; -2^(WIDTH-1) still fits unsigned in WIDTH bits.
    assign neg1 = sgn & in1[WIDTH-1];
    assign neg2 = sgn & in2[WIDTH-1];
    assign mag1 = neg1 ? -in1 : in1;
    assign mag2 = neg2 ? -in2 : in2;
    assign sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out       = out_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: if (in_valid) begin
                mcand_d  = {{WIDTH{1'b0}}, mag1};
                mplier_d = mag2;
                acc_d    = '0;
                cnt_d    = '0;
                neg_d    = neg1 ^ neg2;
                state_d  = RUN;
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    out_d   = neg_q ? -sum : sum;
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            neg_q    <= neg_d;
        end
    end
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: randomized self-checking bench for seq_mult at WIDTH=5 and WIDTH=8.
// Signed cases are exercised when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_mult;
    logic        clk, rst;
    logic [4:0]  a5, b5;
    logic        iv5, ir5, ov5, or5;
    logic [9:0]  o5;
    logic [7:0]  a8, b8;
    logic        iv8, ir8, ov8, or8;
    logic [15:0] o8;
`ifdef SEQ_MULT_SIGNED_EN
    logic        sm5;
`endif
    int vec = 0;
    int err = 0;

    seq_mult #(.WIDTH(5)) u5 (
        .clk(clk), .rst(rst), .in1(a5), .in2(b5), .in_valid(iv5), .in_ready(ir5),
        .out(o5), .out_valid(ov5), .out_ready(or5)
`ifdef SEQ_MULT_SIGNED_EN
        , .signed_mode(sm5)
`endif
    );

    seq_mult #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in1(a8), .in2(b8), .in_valid(iv8), .in_ready(ir8),
        .out(o8), .out_valid(ov8), .out_ready(or8)
`ifdef SEQ_MULT_SIGNED_EN
        , .signed_mode(1'b0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer product of the operands interpreted per mode, reduced to 2*w bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint m, va, vb;
        m  = longint'(1) << w;
        va = longint'(a) & (m - 1);
        vb = longint'(b) & (m - 1);
        if (sgn) begin
            if (va >= m / 2) va -= m;
            if (vb >= m / 2) vb -= m;
        end
        return 64'((va * vb) & (m * m - 1));
    endfunction

    function automatic logic rd_valid(input int w);
        return w == 5 ? ov5 : ov8;
    endfunction

    function automatic logic rd_ready(input int w);
        return w == 5 ? ir5 : ir8;
    endfunction

    function automatic logic [63:0] rd_out(input int w);
        return w == 5 ? 64'(o5) : 64'(o8);
    endfunction

    task automatic set_in(input int w, input logic [31:0] a, input logic [31:0] b, input logic v);
        if (w == 5) begin
            a5 = a[4:0]; b5 = b[4:0]; iv5 = v;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; iv8 = v;
        end
    endtask

    task automatic set_or(input int w, input logic r);
        if (w == 5) or5 = r;
        else or8 = r;
    endtask

    // Drives one operation from a negedge and measures it; returns at a negedge.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input int stall,
                          output int lat, output logic [63:0] res, output bit held_ok, output bit rel_ok);
        int guard;
        held_ok = 1'b1;
        rel_ok  = 1'b1;
        lat     = -1;
        res     = '0;
        guard   = 0;
        while (!rd_ready(w) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        set_or(w, stall == 0);
        set_in(w, a, b, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_in(w, $urandom, $urandom, 1'b0);
        lat = 0;
        while (!rd_valid(w) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!rd_valid(w)) begin
            lat = -1;
            return;
        end
        res = rd_out(w);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!rd_valid(w) || rd_ready(w) || rd_out(w) !== res) held_ok = 1'b0;
        end
        set_or(w, 1'b1);
        @(negedge clk);
        if (rd_valid(w) || !rd_ready(w) || rd_out(w) !== res) rel_ok = 1'b0;
    endtask

    task automatic test_reset;
        #3 rst = 1'b1;
        #1;
        vec++; if (ir5 !== 1'b1) begin err++; $display("FAIL reset_in_ready5: got %b expected 1", ir5); end
        vec++; if (ov5 !== 1'b0) begin err++; $display("FAIL reset_out_valid5: got %b expected 0", ov5); end
        vec++; if (o5 !== 10'd0) begin err++; $display("FAIL reset_out5: got %0d expected 0", o5); end
        vec++; if (ir8 !== 1'b1 || ov8 !== 1'b0 || o8 !== 16'd0) begin
            err++; $display("FAIL reset_w8: got ready=%b valid=%b out=%0d expected 1 0 0", ir8, ov8, o8);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vec++; if (ir5 !== 1'b1 || ov5 !== 1'b0) begin
            err++; $display("FAIL idle_after_reset: got ready=%b valid=%b expected 1 0", ir5, ov5);
        end
    endtask

    task automatic test_all_ones;
        int lat; logic [63:0] res; bit h, r;
        run_op(5, 31, 31, 0, lat, res, h, r);
        vec++; if (lat != 5) begin err++; $display("FAIL ones_latency: got %0d expected 5", lat); end
        vec++; if (res !== 64'd961) begin err++; $display("FAIL ones_product: got %0d expected 961", res); end
        vec++; if (!r) begin err++; $display("FAIL ones_release: got bad release expected valid=0 ready=1"); end
    endtask

    task automatic test_hold;
        int lat; logic [63:0] res; bit h, r;
        run_op(5, 17, 9, 10, lat, res, h, r);
        vec++; if (res !== 64'd153) begin err++; $display("FAIL hold_product: got %0d expected 153", res); end
        vec++; if (!h) begin err++; $display("FAIL hold_stable: got unstable output expected held 153"); end
        vec++; if (!r) begin err++; $display("FAIL hold_release: got bad release expected valid=0 ready=1"); end
        vec++; if (lat != 5) begin err++; $display("FAIL hold_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_zero;
        int lat; logic [63:0] res; bit h, r;
        logic [4:0] za [2] = '{5'd0, 5'd27};
        logic [4:0] zb [2] = '{5'd27, 5'd0};
        for (int i = 0; i < 2; i++) begin
            run_op(5, 32'(za[i]), 32'(zb[i]), i, lat, res, h, r);
            vec++; if (res !== 64'd0) begin err++; $display("FAIL zero_product%0d: got %0d expected 0", i, res); end
            vec++; if (lat != 5) begin err++; $display("FAIL zero_latency%0d: got %0d expected 5", i, lat); end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] q[$];
        int stamps[$];
        int idx = 0, got = 0, cyc = 0, extra = 0;
        logic [31:0] a, b;
        set_or(5, 1'b1);
        while (got < 6 && cyc < 400) begin
            if (ov5) begin
                vec++;
                if (q.size() == 0 || 64'(o5) !== q[0]) begin
                    err++; $display("FAIL b2b_result%0d: got %0d expected %0d", got, o5, q.size() ? q[0] : 64'd0);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            if (ir5 && idx < 6) begin
                a = 32'($urandom_range(1, 31));
                b = 32'($urandom_range(1, 31));
                set_in(5, a, b, 1'b1);
                q.push_back(model(5, a, b, 1'b0));
                stamps.push_back(cyc);
                idx++;
            end else begin
                set_in(5, $urandom, $urandom, idx < 6);
            end
            @(negedge clk);
            cyc++;
        end
        vec++; if (got != 6) begin err++; $display("FAIL b2b_count: got %0d expected 6", got); end
        for (int i = 1; i < stamps.size(); i++) begin
            vec++;
            if (stamps[i] - stamps[i-1] != 7) begin
                err++; $display("FAIL b2b_spacing%0d: got %0d expected 7", i, stamps[i] - stamps[i-1]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            if (ov5) extra++;
            @(negedge clk);
        end
        vec++; if (extra != 0) begin err++; $display("FAIL b2b_duplicate: got %0d extra valid cycles expected 0", extra); end
    endtask

    task automatic test_async_reset;
        int lat; logic [63:0] res; bit h, r;
        set_or(5, 1'b1);
        set_in(5, 12, 13, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_in(5, 0, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        vec++; if (ir5 !== 1'b0) begin err++; $display("FAIL arst_busy: got ready=%b expected 0", ir5); end
        rst = 1'b1;
        #1;
        vec++; if (ir5 !== 1'b1 || ov5 !== 1'b0 || o5 !== 10'd0) begin
            err++; $display("FAIL arst_immediate: got ready=%b valid=%b out=%0d expected 1 0 0", ir5, ov5, o5);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov5 !== 1'b0) begin
                vec++; err++; $display("FAIL arst_partial: got valid=%b expected 0", ov5);
            end
        end
        run_op(5, 3, 4, 0, lat, res, h, r);
        vec++; if (res !== 64'd12) begin err++; $display("FAIL arst_next: got %0d expected 12", res); end
    endtask

    task automatic test_sweep8;
        int lat; logic [63:0] res, exp; bit h, r;
        logic [31:0] a, b;
        for (int i = 0; i <= 200; i++) begin
            a = (i == 200) ? 32'd255 : 32'($urandom_range(0, 255));
            b = (i == 200) ? 32'd255 : 32'($urandom_range(0, 255));
            exp = model(8, a, b, 1'b0);
            run_op(8, a, b, int'($urandom_range(0, 2)), lat, res, h, r);
            vec++; if (res !== exp) begin err++; $display("FAIL sweep8_%0d: %0d*%0d got %0d expected %0d", i, a, b, res, exp); end
            vec++; if (lat != 8 || !h || !r) begin
                err++; $display("FAIL sweep8_hs%0d: got lat=%0d held=%0b rel=%0b expected 8 1 1", i, lat, h, r);
            end
        end
        vec++; if (res !== 64'd65025) begin err++; $display("FAIL sweep8_corner: got %0d expected 65025", res); end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed;
        int lat; logic [63:0] res, exp; bit h, r;
        logic [31:0] a, b;
        logic [4:0]  sa [3] = '{5'd29, 5'd16, 5'd16};
        logic [4:0]  sb [3] = '{5'd7, 5'd16, 5'd15};
        logic [9:0]  sx [3] = '{10'h3EB, 10'd256, 10'h310};
        sm5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(5, 32'(sa[i]), 32'(sb[i]), 0, lat, res, h, r);
            vec++; if (res !== 64'(sx[i])) begin err++; $display("FAIL signed_fixed%0d: got %0h expected %0h", i, res, sx[i]); end
            vec++; if (lat != 5) begin err++; $display("FAIL signed_latency%0d: got %0d expected 5", i, lat); end
        end
        for (int i = 0; i < 100; i++) begin
            a = 32'($urandom_range(0, 31));
            b = 32'($urandom_range(0, 31));
            exp = model(5, a, b, 1'b1);
            run_op(5, a, b, 0, lat, res, h, r);
            vec++; if (res !== exp) begin err++; $display("FAIL signed_rand%0d: %0d*%0d got %0h expected %0h", i, a, b, res, exp); end
        end
        sm5 = 1'b0;
        run_op(5, 31, 31, 0, lat, res, h, r);
        vec++; if (res !== 64'd961) begin err++; $display("FAIL signed_off: got %0d expected 961", res); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        a5 = '0; b5 = '0; iv5 = 1'b0; or5 = 1'b0;
        a8 = '0; b8 = '0; iv8 = 1'b0; or8 = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        sm5 = 1'b0;
`endif
        test_reset();
        test_all_ones();
        test_hold();
        test_zero();
        test_back_to_back();
        test_async_reset();
        test_sweep8();
`ifdef SEQ_MULT_SIGNED_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
